conv_window_mac: RTL and testbench



---
 rtl/conv_pkg.sv | 27 ++
 rtl/conv_window_mac_if.sv | 33 +++
 rtl/conv_mac_row.sv | 45 ++++
 rtl/conv_window_mac.sv | 129 ++++++++++++
 tb/tb_conv_window_mac.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_pkg.sv
// Shared sizing helpers and reset constants for the KxK convolution engine.
package conv_pkg;

    // Number of pipeline stages: window, products, row sums, total/clip.
    localparam int STAGES = 4;

    // Signed product of a zero-extended pixel and a signed coefficient.
    function automatic int prod_w(input int data_w, input int coef_w);
        return data_w + coef_w + 1;
    endfunction

    // Accumulator wide enough for KERNEL*KERNEL products without overflow.
    function automatic int acc_w(input int data_w, input int coef_w, input int kernel);
        return prod_w(data_w, coef_w) + $clog2(kernel * kernel);
    endfunction

    // Flat coefficient index, row 0 is the top (oldest) window row.
    function automatic int coef_idx(input int row, input int col, input int kernel);
        return row * kernel + col;
    endfunction

    // Identity kernel: 1.0 in the centre tap, zero elsewhere.
    function automatic int identity_coef(input int idx, input int kernel, input int frac);
        return (idx == coef_idx(kernel / 2, kernel / 2, kernel)) ? (1 << frac) : 0;
    endfunction

endpackage

// File: rtl/conv_window_mac_if.sv
// Row stream in, pixel stream out, coefficient write port and row pass-through.
interface conv_window_mac_if #(
    parameter int KERNEL = 3,
    parameter int DATA_W = 8,
    parameter int COEF_W = 10,
    parameter int OUT_W  = 8
);
    localparam int ADDR_W = $clog2(KERNEL * KERNEL);

    logic                       coef_wr_en;
    logic [ADDR_W-1:0]          coef_wr_addr;
    logic [COEF_W-1:0]          coef_wr_data;
    logic                       in_valid;
    logic                       in_ready;
    logic                       in_sof;
    logic [KERNEL*DATA_W-1:0]   in_row;
    logic [KERNEL*DATA_W-1:0]   pass_row;
    logic                       out_valid;
    logic                       out_ready;
    logic [OUT_W-1:0]           out_data;

    modport master (
        output coef_wr_en, coef_wr_addr, coef_wr_data,
        output in_valid, in_sof, in_row, out_ready,
        input  in_ready, pass_row, out_valid, out_data
    );

    modport slave (
        input  coef_wr_en, coef_wr_addr, coef_wr_data,
        input  in_valid, in_sof, in_row, out_ready,
        output in_ready, pass_row, out_valid, out_data
    );
endinterface

// File: rtl/conv_mac_row.sv
// One window row times its KERNEL coefficients: registered products (S2)
// then a registered signed row sum (S3). Both stages hold when advance is low.
module conv_mac_row import conv_pkg::*; #(
    parameter int KERNEL = 3,
    parameter int DATA_W = 8,
    parameter int COEF_W = 10,
    parameter int ACC_W  = acc_w(8, 10, 3)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            advance,
    input  logic [KERNEL-1:0][DATA_W-1:0]   pix,
    input  logic [KERNEL-1:0][COEF_W-1:0]   coef,
    output logic [ACC_W-1:0]                sum
);
    localparam int PROD_W = prod_w(DATA_W, COEF_W);

    logic signed [PROD_W-1:0] prod [KERNEL];
    logic signed [ACC_W-1:0]  row_total;

    // S2: pixel (zero-extended) times signed coefficient, per column.
    always_ff @(posedge clk) begin
        for (int c = 0; c < KERNEL; c++) begin
            if (reset)
                prod[c] <= '0;
            else if (advance)
                prod[c] <= PROD_W'($signed({1'b0, pix[c]})) * PROD_W'($signed(coef[c]));
        end
    end

    // Sign-extend and add the column products.
    always_comb begin
        row_total = '0;
        for (int c = 0; c < KERNEL; c++)
            row_total = row_total + ACC_W'(prod[c]);
    end

    // S3: register the row sum.
    always_ff @(posedge clk) begin
        if (reset)
            sum <= '0;
        else if (advance)
            sum <= row_total;
    end
endmodule

// File: rtl/conv_window_mac.sv
// KxK sliding-window convolution: rows shift up into the window, each full
// window launches a token through products, row sums and a final
// shift/clip stage. Whole pipeline stalls together on !out_ready.
// Optional: define CONV_SATURATE_EN to clip results instead of wrapping.
module conv_window_mac import conv_pkg::*; #(
    parameter int KERNEL    = 3,
    parameter int DATA_W    = 8,
    parameter int COEF_W    = 10,
    parameter int FRAC_BITS = 8,
    parameter int OUT_W     = 8
) (
    input  logic            clk,
    input  logic            reset,
    conv_window_mac_if.slave bus
);
    localparam int NCOEF  = KERNEL * KERNEL;
    localparam int ADDR_W = $clog2(NCOEF);
    localparam int ACC_W  = acc_w(DATA_W, COEF_W, KERNEL);
    localparam int FILL_W = $clog2(KERNEL + 1);

    logic                                       advance;
    logic                                       accept;
    logic                                       launch;
    logic [KERNEL-1:0][KERNEL-1:0][DATA_W-1:0]  win;
    logic [NCOEF-1:0][COEF_W-1:0]               coef;
    logic [FILL_W-1:0]                          fill;
    logic [FILL_W-1:0]                          fill_nxt;
    logic [STAGES-1:0]                          vld_pipe;
    logic [KERNEL-1:0][ACC_W-1:0]               row_sum;
    logic signed [ACC_W-1:0]                    total;
    logic signed [ACC_W-1:0]                    shifted;
    logic [OUT_W-1:0]                           res;

    assign advance       = !vld_pipe[STAGES-1] || bus.out_ready;
    assign accept        = bus.in_valid && advance;
    assign bus.in_ready  = advance;
    assign bus.out_valid = vld_pipe[STAGES-1];
    assign bus.pass_row  = win[0];

    // Fill count after this accept; a token launches once the window is full.
    always_comb begin
        fill_nxt = fill;
        if (bus.in_sof)
            fill_nxt = FILL_W'(1);
        else if (fill != FILL_W'(KERNEL))
            fill_nxt = fill + 1'b1;
        launch = accept && (fill_nxt == FILL_W'(KERNEL));
    end

    // S1: window shift, fill tracking and the valid shift register.
    always_ff @(posedge clk) begin
        if (reset) begin
            win      <= '0;
            fill     <= '0;
            vld_pipe <= '0;
        end else if (advance) begin
            vld_pipe <= {vld_pipe[STAGES-2:0], launch};
            if (accept) begin
                for (int r = 0; r < KERNEL - 1; r++)
                    win[r] <= win[r+1];
                win[KERNEL-1] <= bus.in_row;
                fill          <= fill_nxt;
            end
        end
    end

    // Coefficient RAM; addresses past the last tap match no entry.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NCOEF; i++) begin
            if (reset)
                coef[i] <= COEF_W'(identity_coef(i, KERNEL, FRAC_BITS));
            else if (bus.coef_wr_en && bus.coef_wr_addr == ADDR_W'(i))
                coef[i] <= bus.coef_wr_data;
        end
    end

    for (genvar r = 0; r < KERNEL; r++) begin : g_row
        conv_mac_row #(
            .KERNEL (KERNEL),
            .DATA_W (DATA_W),
            .COEF_W (COEF_W),
            .ACC_W  (ACC_W)
        ) u_row (
            .clk     (clk),
            .reset   (reset),
            .advance (advance),
            .pix     (win[r]),
            .coef    (coef[r*KERNEL +: KERNEL]),
            .sum     (row_sum[r])
        );
    end

    // S4 combinational: total, floor shift, then clip or wrap to OUT_W.
`ifdef CONV_SATURATE_EN
    localparam logic signed [ACC_W-1:0] OUT_MAX = ACC_W'((1 << OUT_W) - 1);

    always_comb begin
        total = '0;
        for (int r = 0; r < KERNEL; r++)
            total = total + $signed(row_sum[r]);
        shifted = total >>> FRAC_BITS;
        if (shifted < 0)
            res = '0;
        else if (shifted > OUT_MAX)
            res = '1;
        else
            res = shifted[OUT_W-1:0];
    end
`else
    logic unused_hi;
    assign unused_hi = ^shifted[ACC_W-1:OUT_W];

    always_comb begin
        total = '0;
        for (int r = 0; r < KERNEL; r++)
            total = total + $signed(row_sum[r]);
        shifted = total >>> FRAC_BITS;
        res     = shifted[OUT_W-1:0];
    end
`endif

    // S4 register: result holds while the consumer stalls.
    always_ff @(posedge clk) begin
        if (reset)
            bus.out_data <= '0;
        else if (advance)
            bus.out_data <= res;
    end
endmodule

// File: tb/tb_conv_window_mac.sv
// Randomised bench for conv_window_mac with a window/coefficient model and
// an expected-result queue.
module tb_conv_window_mac;
    localparam int K  = 3;
    localparam int D  = 8;
    localparam int C  = 10;
    localparam int F  = 8;
    localparam int O  = 8;
    localparam int NC = K * K;
    localparam int AW = $clog2(NC);

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    conv_window_mac_if #(.KERNEL(K), .DATA_W(D), .COEF_W(C), .OUT_W(O)) bus ();

    conv_window_mac #(.KERNEL(K), .DATA_W(D), .COEF_W(C), .FRAC_BITS(F), .OUT_W(O)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // Reference model state
    int     mwin [K][K];
    int     mcoef [NC];
    int     mfill;
    longint expq [$];
    int     n_out;
    longint last_out;
    bit     hold_prev;
    longint hold_data;

    function automatic longint model_pixel();
        longint s = 0;
        for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
                s += longint'(mwin[r][c]) * longint'(mcoef[r*K+c]);
        s = s >>> F;
`ifdef CONV_SATURATE_EN
        if (s < 0) s = 0;
        else if (s > (1 << O) - 1) s = (1 << O) - 1;
`else
        s = s & ((1 << O) - 1);
`endif
        return s;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
                mwin[r][c] = 0;
        for (int i = 0; i < NC; i++)
            mcoef[i] = (i == NC / 2) ? (1 << F) : 0;
        mfill = 0;
        expq.delete();
        hold_prev = 1'b0;
    endtask

    task automatic model_accept(input logic [K*D-1:0] row, input bit sof);
        for (int r = 0; r < K - 1; r++)
            for (int c = 0; c < K; c++)
                mwin[r][c] = mwin[r+1][c];
        for (int c = 0; c < K; c++)
            mwin[K-1][c] = int'(row[c*D +: D]);
        if (sof) mfill = 1;
        else if (mfill < K) mfill++;
        if (mfill == K) expq.push_back(model_pixel());
    endtask

    function automatic logic [K*D-1:0] row_of(input int v);
        logic [K*D-1:0] r;
        for (int c = 0; c < K; c++) r[c*D +: D] = D'(v);
        return r;
    endfunction

    function automatic logic [K*D-1:0] row_rand();
        logic [K*D-1:0] r;
        for (int c = 0; c < K; c++) r[c*D +: D] = D'($urandom);
        return r;
    endfunction

    // One cycle: drive at negedge, check what the coming edge will transfer.
    task automatic cyc(input bit v, input bit sof, input logic [K*D-1:0] row, input bit rdy);
        longint e;
        @(negedge clk);
        bus.in_valid  = v;
        bus.in_sof    = sof;
        bus.in_row    = row;
        bus.out_ready = rdy;
        #1;
        if (hold_prev) begin
            chk("hold_vld", bus.out_valid, 1);
            chk("hold_data", bus.out_data, hold_data);
        end
        chk("in_ready", bus.in_ready, (!bus.out_valid || rdy) ? 1 : 0);
        if (bus.out_valid && rdy) begin
            n_out++;
            chk("out_expected", (expq.size() > 0) ? 1 : 0, 1);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("out_data", bus.out_data, e);
                last_out = bus.out_data;
            end
        end
        hold_prev = bus.out_valid && !rdy;
        hold_data = bus.out_data;
        if (v && bus.in_ready) model_accept(row, sof);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && (expq.size() > 0 || bus.out_valid); i++)
            cyc(1'b0, 1'b0, '0, 1'b1);
        chk("drain", expq.size(), 0);
    endtask

    task automatic wr_coef(input int a, input int val);
        @(negedge clk);
        bus.coef_wr_en   = 1'b1;
        bus.coef_wr_addr = AW'(a);
        bus.coef_wr_data = C'(val);
        if (a < NC) mcoef[a] = val;
        @(posedge clk);
        #1 bus.coef_wr_en = 1'b0;
    endtask

    task automatic set_all_coef(input int val);
        for (int i = 0; i < NC; i++) wr_coef(i, val);
    endtask

    task automatic set_rand_coef();
        for (int i = 0; i < NC; i++) wr_coef(i, int'($urandom_range(1023)) - 512);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int o0;
        reset = 1'b1;
        bus.in_valid = 1'b0; bus.in_sof = 1'b0; bus.in_row = '0; bus.out_ready = 1'b0;
        bus.coef_wr_en = 1'b0; bus.coef_wr_addr = '0; bus.coef_wr_data = '0;
        n_out = 0; last_out = 0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_pass_row", bus.pass_row, 0);
        reset = 1'b0;

        // Identity kernel, flat 100: latency of exactly three edges.
        repeat (3) cyc(1'b1, 1'b0, row_of(100), 1'b1);
        cyc(1'b0, 1'b0, '0, 1'b1);
        chk("lat_early", bus.out_valid, 0);
        chk("pass_row", bus.pass_row, row_of(100));
        cyc(1'b0, 1'b0, '0, 1'b1);
        chk("lat_early", bus.out_valid, 0);
        cyc(1'b0, 1'b0, '0, 1'b1);
        chk("lat_early", bus.out_valid, 0);
        cyc(1'b0, 1'b0, '0, 1'b1);
        chk("lat", bus.out_valid, 1);
        chk("id100", last_out, 100);
        drain();

        // Box filter approx 1/9 on flat 90.
        set_all_coef(28);
        repeat (3) cyc(1'b1, 1'b0, row_of(90), 1'b1);
        drain();
        chk("avg28", last_out, 88);

        // Negative centre tap.
        set_all_coef(0);
        wr_coef(NC / 2, -256);
        wr_coef(NC, 300);   // out of range, must be ignored
        repeat (3) cyc(1'b1, 1'b0, row_of(50), 1'b1);
        drain();
`ifdef CONV_SATURATE_EN
        chk("neg_centre", last_out, 0);
`else
        chk("neg_centre", last_out, 206);
`endif

        // Large positive gain on full-scale pixels.
        set_all_coef(511);
        repeat (3) cyc(1'b1, 1'b0, row_of(255), 1'b1);
        drain();
`ifdef CONV_SATURATE_EN
        chk("big_gain", last_out, 255);
`else
        chk("big_gain", last_out, 229);
`endif

        // Stall mid-stream: nothing lost, nothing duplicated, output held.
        set_rand_coef();
        repeat (3) cyc(1'b1, 1'b0, row_rand(), 1'b1);
        repeat (5) cyc(1'b1, 1'b0, row_rand(), 1'b0);
        chk("stall_in_ready", bus.in_ready, 0);
        repeat (4) cyc(1'b1, 1'b0, row_rand(), 1'b1);
        drain();

        // Start of frame: two quiet accepts, the third emits.
        repeat (5) cyc(1'b1, 1'b0, row_rand(), 1'b1);
        drain();
        o0 = n_out;
        cyc(1'b1, 1'b1, row_rand(), 1'b1);
        cyc(1'b1, 1'b0, row_rand(), 1'b1);
        drain();
        chk("sof_quiet", n_out - o0, 0);
        cyc(1'b1, 1'b0, row_rand(), 1'b1);
        drain();
        chk("sof_third", n_out - o0, 1);

        // Reset with tokens in flight.
        repeat (3) cyc(1'b1, 1'b0, row_rand(), 1'b1);
        @(negedge clk);
        reset = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("rst_mid_vld", bus.out_valid, 0);
        chk("rst_mid_pass", bus.pass_row, 0);
        reset = 1'b0;
        model_reset();
        o0 = n_out;
        repeat (2) cyc(1'b1, 1'b0, row_rand(), 1'b1);
        drain();
        chk("rst_refill", n_out - o0, 0);
        cyc(1'b1, 1'b0, row_rand(), 1'b1);
        drain();
        chk("rst_first", n_out - o0, 1);

        // Random traffic with random coefficients.
        set_rand_coef();
        for (int i = 0; i < 400; i++)
            cyc(($urandom % 4) != 0, ($urandom % 16) == 0, row_rand(), ($urandom % 3) != 0);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
